// File: rtl/structural_decoder.sv
// Two-to-four line decoder built from gate primitives, with one register stage
// so the one-hot selects change only on a clock edge or on reset.
module structural_decoder (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic address0,
  input  logic address1,
  output logic out0,
  output logic out1,
  output logic out2,
  output logic out3
);

  // Primitive outputs must be nets, so the decode core uses wires.
  wire na0;
  wire na1;
  wire d0;
  wire d1;
  wire d2;
  wire d3;

  not u_not_a0 (na0, address0);
  not u_not_a1 (na1, address1);

  and u_and_d0 (d0, enable, na0,      na1);
  and u_and_d1 (d1, enable, address0, na1);
  and u_and_d2 (d2, enable, na0,      address1);
  and u_and_d3 (d3, enable, address0, address1);

  logic [3:0] sel_d;
  logic [3:0] sel_q;

  assign sel_d = {d3, d2, d1, d0};

  // NOTE: non-blocking assignment keeps all four selects updating together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 4'b0000;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign out0 = sel_q[0];
  assign out1 = sel_q[1];
  assign out2 = sel_q[2];
  assign out3 = sel_q[3];

endmodule

// File: tb/tb_structural_decoder.sv
// Self-checking bench for structural_decoder: table-driven sweeps through a
// scoreboard queue plus hand-written reset, latency and enable-toggle sequences.
module tb_structural_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic address0;
  logic address1;
  logic out0;
  logic out1;
  logic out2;
  logic out3;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  string      name_q[$];

  typedef struct {
    logic       en;
    logic       a0;
    logic       a1;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[8];

  structural_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .address0 (address0),
    .address1 (address1),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {out3, out2, out1, out0};
  endfunction

  function automatic logic [3:0] model(input logic en, input logic a0, input logic a1);
    logic [1:0] idx;
    idx = {a1, a0};
    return en ? (4'b0001 << idx) : 4'b0000;
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: out3..0 got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Drive at the falling edge and queue what the next rising edge must produce.
  task automatic drive(input logic en, input logic a0, input logic a1, input string name);
    @(negedge clk);
    enable   = en;
    address0 = a0;
    address1 = a1;
    exp_q.push_back(model(en, a0, a1));
    name_q.push_back(name);
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: empty queue at %0t", $time);
    end else begin
      check(name_q.pop_front(), outs(), exp_q.pop_front());
    end
  endtask

  initial begin
    vecs[0] = '{en: 1'b1, a0: 1'b0, a1: 1'b0, exp: 4'b0001};
    vecs[1] = '{en: 1'b1, a0: 1'b1, a1: 1'b0, exp: 4'b0010};
    vecs[2] = '{en: 1'b1, a0: 1'b0, a1: 1'b1, exp: 4'b0100};
    vecs[3] = '{en: 1'b1, a0: 1'b1, a1: 1'b1, exp: 4'b1000};
    vecs[4] = '{en: 1'b0, a0: 1'b0, a1: 1'b0, exp: 4'b0000};
    vecs[5] = '{en: 1'b0, a0: 1'b1, a1: 1'b0, exp: 4'b0000};
    vecs[6] = '{en: 1'b0, a0: 1'b0, a1: 1'b1, exp: 4'b0000};
    vecs[7] = '{en: 1'b0, a0: 1'b1, a1: 1'b1, exp: 4'b0000};

    // Reset with enable=1, address=11 and the clock running.
    rst_n    = 1'b1;
    enable   = 1'b1;
    address0 = 1'b1;
    address1 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", outs(), 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold_%0d", i), outs(), 4'b0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, "reset_release");
    sample();

    // Enabled and disabled sweeps, each vector held for three clocks.
    for (int v = 0; v < 8; v++) begin
      for (int h = 0; h < 3; h++) begin
        drive(vecs[v].en, vecs[v].a0, vecs[v].a1, $sformatf("vec%0d_hold%0d", v, h));
        sample();
        check($sformatf("vec%0d_table_%0d", v, h), outs(), vecs[v].exp);
      end
    end

    // Latency: address 00 -> 11 just after a rising edge.
    drive(1'b1, 1'b0, 1'b0, "latency_start");
    sample();
    address0 = 1'b1;
    address1 = 1'b1;
    exp_q.push_back(4'b1000);
    name_q.push_back("latency_after_edge");
    @(negedge clk);
    check("latency_before_edge", outs(), 4'b0001);
    sample();

    // Enable toggle with address 10.
    drive(1'b1, 1'b0, 1'b1, "toggle_en1");
    sample();
    drive(1'b0, 1'b0, 1'b1, "toggle_en0");
    sample();
    drive(1'b1, 1'b0, 1'b1, "toggle_en1_again");
    sample();

    // Mid-operation reset pulsed between edges.
    drive(1'b1, 1'b1, 1'b0, "mid_step_01");
    sample();
    drive(1'b1, 1'b0, 1'b1, "mid_step_10");
    sample();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_immediate", outs(), 4'b0000);
    @(posedge clk);
    #1;
    check("mid_reset_over_edge", outs(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    enable   = 1'b1;
    address0 = 1'b1;
    address1 = 1'b1;
    exp_q.push_back(model(1'b1, 1'b1, 1'b1));
    name_q.push_back("mid_reset_resume");
    sample();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
